// File: rtl/ea_unit_if.sv
// Memory port of the PDP-8 effective-address unit: one request/ack transaction
// at a time, read data valid in the ack cycle.
interface ea_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/ea_unit.sv
// PDP-8 effective-address unit for memory-reference instructions: resolves
// page-zero/current-page, indirect and auto-index addressing; drives PC load on JMP.
module ea_unit #(
    parameter bit AUTOINDEX_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [11:0] i_ir,
    input  logic [11:0] i_pclat,
    ea_unit_if.master   mem,
    output logic        o_busy,
    output logic        o_done,
    output logic [11:0] o_ea,
    output logic        o_pc_ld,
    output logic [11:0] o_pc_in
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WB, S_DONE} state_t;

    state_t      r_state, w_state_next;
    logic        r_mri, w_mri_next;
    logic        r_jmp, w_jmp_next;
    logic        r_ind, w_ind_next;
    logic        r_auto, w_auto_next;
    logic [11:0] r_dir, w_dir_next;
    logic [11:0] r_ptr, w_ptr_next;
    logic        r_req, w_req_next;
    logic        r_we, w_we_next;
    logic [11:0] r_addr, w_addr_next;
    logic [11:0] r_wdata, w_wdata_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic [11:0] r_ea, w_ea_next;
    logic        r_pc_ld, w_pc_ld_next;
    logic [11:0] r_pc_in, w_pc_in_next;

    logic [11:0] w_dir_addr;
    logic        w_is_auto;
    logic [11:0] w_final;
    logic        w_unused_pclat;

    // Only the page field of the latched PC matters for current-page addressing.
    assign w_dir_addr     = i_ir[7] ? {i_pclat[11:7], i_ir[6:0]} : {5'b0, i_ir[6:0]};
    assign w_is_auto      = AUTOINDEX_EN && i_ir[8] && (w_dir_addr[11:3] == 9'o001);
    assign w_final        = r_ind ? r_ptr : r_dir;
    assign w_unused_pclat = ^i_pclat[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mri   <= 1'b0;
            r_jmp   <= 1'b0;
            r_ind   <= 1'b0;
            r_auto  <= 1'b0;
            r_dir   <= 12'd0;
            r_ptr   <= 12'd0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 12'd0;
            r_wdata <= 12'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ea    <= 12'd0;
            r_pc_ld <= 1'b0;
            r_pc_in <= 12'd0;
        end else begin
            r_state <= w_state_next;
            r_mri   <= w_mri_next;
            r_jmp   <= w_jmp_next;
            r_ind   <= w_ind_next;
            r_auto  <= w_auto_next;
            r_dir   <= w_dir_next;
            r_ptr   <= w_ptr_next;
            r_req   <= w_req_next;
            r_we    <= w_we_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_ea    <= w_ea_next;
            r_pc_ld <= w_pc_ld_next;
            r_pc_in <= w_pc_in_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mri_next   = r_mri;
        w_jmp_next   = r_jmp;
        w_ind_next   = r_ind;
        w_auto_next  = r_auto;
        w_dir_next   = r_dir;
        w_ptr_next   = r_ptr;
        w_req_next   = r_req;
        w_we_next    = r_we;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_ea_next    = r_ea;
        w_pc_ld_next = 1'b0;
        w_pc_in_next = r_pc_in;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_mri_next  = ~(i_ir[11] & i_ir[10]);
                    w_jmp_next  = (i_ir[11:9] == 3'd5);
                    w_ind_next  = i_ir[8];
                    w_auto_next = w_is_auto;
                    w_dir_next  = w_dir_addr;
                    w_busy_next = 1'b1;
                    // IOT/OPR words (6, 7) pass through with no address work.
                    if (i_ir[8] && !(i_ir[11] & i_ir[10])) begin
                        w_state_next = S_RD;
                        w_req_next   = 1'b1;
                        w_we_next    = 1'b0;
                        w_addr_next  = w_dir_addr;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_RD: begin
                if (mem.mem_ack) begin
                    if (r_auto) begin
                        // Request stays up; the write-back reuses the same address.
                        w_ptr_next   = mem.mem_rdata + 12'd1;
                        w_wdata_next = mem.mem_rdata + 12'd1;
                        w_we_next    = 1'b1;
                        w_state_next = S_WB;
                    end else begin
                        w_ptr_next   = mem.mem_rdata;
                        w_req_next   = 1'b0;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_WB: begin
                if (mem.mem_ack) begin
                    w_req_next   = 1'b0;
                    w_we_next    = 1'b0;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
                if (r_mri) begin
                    w_ea_next = w_final;
                end
                if (r_jmp) begin
                    w_pc_ld_next = 1'b1;
                    w_pc_in_next = w_final;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_ea          = r_ea;
    assign o_pc_ld       = r_pc_ld;
    assign o_pc_in       = r_pc_in;
endmodule

// File: tb/tb_ea_unit.sv
// Bench for ea_unit: auto-index instance (A) and plain-indirect instance (B)
// against a latency-programmable memory responder.
module tb_ea_unit;
    logic        clk;
    logic        reset;
    logic        start_a, start_b;
    logic [11:0] ir, pclat;
    logic        busy_a, done_a, pcld_a, busy_b, done_b, pcld_b;
    logic [11:0] ea_a, pcin_a, ea_b, pcin_b;

    ea_unit_if mif_a ();
    ea_unit_if mif_b ();

    ea_unit #(.AUTOINDEX_EN(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .i_start(start_a), .i_ir(ir), .i_pclat(pclat),
        .mem(mif_a.master), .o_busy(busy_a), .o_done(done_a), .o_ea(ea_a),
        .o_pc_ld(pcld_a), .o_pc_in(pcin_a)
    );
    ea_unit #(.AUTOINDEX_EN(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .i_start(start_b), .i_ir(ir), .i_pclat(pclat),
        .mem(mif_b.master), .o_busy(busy_b), .o_done(done_b), .o_ea(ea_b),
        .o_pc_ld(pcld_b), .o_pc_in(pcin_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder state; mem is written only by the stimulus process.
    logic [11:0] mem [0:4095];
    logic        ack_v [2];
    logic [11:0] rdata_v [2];
    int          cnt [2];
    int          n_rd [2];
    int          n_wr [2];
    logic [11:0] rd_addr [2];
    logic [11:0] wr_addr [2];
    logic [11:0] wr_data [2];
    logic [11:0] first_addr [2];
    bit          addr_bad [2];
    int          ack_lat;
    bit          ack_block_wr;
    int          force_req, force_seen;
    int          done_cnt [2];
    int          pcld_cnt [2];

    assign mif_a.mem_ack   = ack_v[0];
    assign mif_a.mem_rdata = rdata_v[0];
    assign mif_b.mem_ack   = ack_v[1];
    assign mif_b.mem_rdata = rdata_v[1];

    initial begin
        for (int i = 0; i < 2; i++) begin
            ack_v[i] = 1'b0; rdata_v[i] = 12'd0; cnt[i] = 0; n_rd[i] = 0; n_wr[i] = 0;
            rd_addr[i] = 12'd0; wr_addr[i] = 12'd0; wr_data[i] = 12'd0;
            first_addr[i] = 12'd0; addr_bad[i] = 1'b0;
            done_cnt[i] = 0; pcld_cnt[i] = 0;
        end
        force_seen = 0;
    end

    always @(negedge clk) begin
        logic        req, we;
        logic [11:0] addr, wd;
        for (int s = 0; s < 2; s++) begin
            req  = (s == 0) ? mif_a.mem_req   : mif_b.mem_req;
            we   = (s == 0) ? mif_a.mem_we    : mif_b.mem_we;
            addr = (s == 0) ? mif_a.mem_addr  : mif_b.mem_addr;
            wd   = (s == 0) ? mif_a.mem_wdata : mif_b.mem_wdata;
            if (ack_v[s]) begin
                ack_v[s] = 1'b0;
                cnt[s]   = 0;
            end else if (req) begin
                if (cnt[s] == 0) first_addr[s] = addr;
                else if (addr != first_addr[s]) addr_bad[s] = 1'b1;
                cnt[s]++;
                if (cnt[s] >= ack_lat && !(we && ack_block_wr)) begin
                    ack_v[s] = 1'b1;
                    if (we) begin
                        n_wr[s]++; wr_addr[s] = addr; wr_data[s] = wd;
                    end else begin
                        n_rd[s]++; rd_addr[s] = addr; rdata_v[s] = mem[addr];
                    end
                end
            end else begin
                cnt[s] = 0;
            end
        end
        // Stray ack on instance A, presented with no request outstanding.
        if (force_req > force_seen) begin
            force_seen++;
            ack_v[0] = 1'b1;
        end
        if (done_a) done_cnt[0]++;
        if (done_b) done_cnt[1]++;
        if (pcld_a) pcld_cnt[0]++;
        if (pcld_b) pcld_cnt[1]++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    function automatic logic get_done(input bit s);  return s ? done_b : done_a;  endfunction
    function automatic logic get_busy(input bit s);  return s ? busy_b : busy_a;  endfunction
    function automatic logic get_pcld(input bit s);  return s ? pcld_b : pcld_a;  endfunction
    function automatic logic [11:0] get_ea(input bit s);   return s ? ea_b : ea_a;     endfunction
    function automatic logic [11:0] get_pcin(input bit s); return s ? pcin_b : pcin_a; endfunction

    typedef struct {
        bit          sel;
        logic [11:0] ir;
        logic [11:0] pclat;
        logic [11:0] maddr;
        logic [11:0] mval;
        int          lat;
        logic [11:0] exp_ea;
        bit          exp_pcld;
        logic [11:0] exp_pcin;
        int          exp_nrd;
        int          exp_nwr;
        logic [11:0] exp_wdata;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [9];

    task automatic pulse_start(input bit s);
        @(negedge clk);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  rd0, wr0, cyc;
        bit  got, busy_ok;
        rd0 = n_rd[v.sel];
        wr0 = n_wr[v.sel];
        mem[v.maddr] = v.mval;
        ack_lat = v.lat;
        @(negedge clk);
        ir = v.ir;
        pclat = v.pclat;
        if (v.sel) start_b = 1'b1; else start_a = 1'b1;
        cyc = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && cyc < 60) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            cyc++;
            if (get_done(v.sel)) got = 1'b1;
            else if (!get_busy(v.sel)) busy_ok = 1'b0;
        end
        $display("vec %0d: dut=%0d ir=%04o pclat=%04o ea=%04o pc_ld=%0d pc_in=%04o cycles=%0d",
                 idx, v.sel, v.ir, v.pclat, get_ea(v.sel), get_pcld(v.sel), get_pcin(v.sel), cyc);
        chk($sformatf("v%0d_done_seen", idx), 32'(got), 32'd1);
        if (v.exp_cycles > 0) chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.exp_cycles));
        chk($sformatf("v%0d_ea", idx), 32'(get_ea(v.sel)), 32'(v.exp_ea));
        chk($sformatf("v%0d_pc_ld", idx), 32'(get_pcld(v.sel)), 32'(v.exp_pcld));
        chk($sformatf("v%0d_pc_in", idx), 32'(get_pcin(v.sel)), 32'(v.exp_pcin));
        chk($sformatf("v%0d_busy_at_done", idx), 32'(get_busy(v.sel)), 32'd0);
        chk($sformatf("v%0d_busy_held", idx), 32'(busy_ok), 32'd1);
        chk($sformatf("v%0d_reads", idx), 32'(n_rd[v.sel] - rd0), 32'(v.exp_nrd));
        chk($sformatf("v%0d_writes", idx), 32'(n_wr[v.sel] - wr0), 32'(v.exp_nwr));
        if (v.exp_nrd > 0) chk($sformatf("v%0d_rd_addr", idx), 32'(rd_addr[v.sel]), 32'(v.maddr));
        if (v.exp_nwr > 0) begin
            chk($sformatf("v%0d_wr_addr", idx), 32'(wr_addr[v.sel]), 32'(v.maddr));
            chk($sformatf("v%0d_wr_data", idx), 32'(wr_data[v.sel]), 32'(v.exp_wdata));
        end
        @(negedge clk);
        chk($sformatf("v%0d_done_width", idx), 32'(get_done(v.sel)), 32'd0);
        chk($sformatf("v%0d_pc_ld_width", idx), 32'(get_pcld(v.sel)), 32'd0);
    endtask

    initial begin
        int d0, p0, rd0, waited;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; ir = 12'd0; pclat = 12'd0;
        ack_lat = 1; ack_block_wr = 1'b0; force_req = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 12'd0;

        //           sel ir        pclat     maddr     mval      lat ea        pcld pc_in     rd wr wdata     cycles
        vecs[0] = '{1'b0, 12'o1123, 12'o1234, 12'o0000, 12'o0000, 1, 12'o0123, 1'b0, 12'o0000, 0, 0, 12'o0000, 2};
        vecs[1] = '{1'b0, 12'o1323, 12'o2345, 12'o0000, 12'o0000, 1, 12'o2323, 1'b0, 12'o0000, 0, 0, 12'o0000, 2};
        vecs[2] = '{1'b0, 12'o1420, 12'o0000, 12'o0020, 12'o4567, 3, 12'o4567, 1'b0, 12'o0000, 1, 0, 12'o0000, 5};
        vecs[3] = '{1'b0, 12'o3410, 12'o0000, 12'o0010, 12'o7777, 1, 12'o0000, 1'b0, 12'o0000, 1, 1, 12'o0000, 5};
        vecs[4] = '{1'b1, 12'o3410, 12'o0000, 12'o0010, 12'o7777, 1, 12'o7777, 1'b0, 12'o0000, 1, 0, 12'o0000, 3};
        vecs[5] = '{1'b0, 12'o5610, 12'o0205, 12'o0210, 12'o3000, 1, 12'o3000, 1'b1, 12'o3000, 1, 0, 12'o0000, 3};
        vecs[6] = '{1'b0, 12'o5610, 12'o0005, 12'o0010, 12'o3000, 1, 12'o3001, 1'b1, 12'o3001, 1, 1, 12'o3001, 5};
        vecs[7] = '{1'b0, 12'o6400, 12'o0000, 12'o0000, 12'o0000, 1, 12'o3001, 1'b0, 12'o3001, 0, 0, 12'o0000, 2};
        vecs[8] = '{1'b0, 12'o5077, 12'o4000, 12'o0000, 12'o0000, 1, 12'o0077, 1'b1, 12'o0077, 0, 0, 12'o0000, 2};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_req_a", 32'(mif_a.mem_req), 32'd0);
        chk("rst_mem_we_a", 32'(mif_a.mem_we), 32'd0);
        chk("rst_mem_addr_a", 32'(mif_a.mem_addr), 32'd0);
        chk("rst_mem_wdata_a", 32'(mif_a.mem_wdata), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_ea_a", 32'(ea_a), 32'd0);
        chk("rst_pc_ld_a", 32'(pcld_a), 32'd0);
        chk("rst_pc_in_a", 32'(pcin_a), 32'd0);
        chk("rst_mem_req_b", 32'(mif_b.mem_req), 32'd0);
        chk("rst_ea_b", 32'(ea_b), 32'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);
        chk("addr_stable_a", 32'(addr_bad[0]), 32'd0);
        chk("addr_stable_b", 32'(addr_bad[1]), 32'd0);

        // Abort in the write-back with the ack held off, then a stray ack.
        mem[12'o0010] = 12'o0100;
        ack_lat = 1;
        ack_block_wr = 1'b1;
        ir = 12'o3410;
        pclat = 12'o0000;
        pulse_start(1'b0);
        waited = 0;
        while (!mif_a.mem_we && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_reached_wb", 32'(mif_a.mem_we & mif_a.mem_req), 32'd1);
        d0 = done_cnt[0];
        p0 = pcld_cnt[0];
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("abort: mem_req=%0d mem_we=%0d busy=%0d ea=%04o", mif_a.mem_req, mif_a.mem_we, busy_a, ea_a);
        chk("abort_mem_req", 32'(mif_a.mem_req), 32'd0);
        chk("abort_mem_we", 32'(mif_a.mem_we), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_ea", 32'(ea_a), 32'd0);
        chk("abort_pc_in", 32'(pcin_a), 32'd0);
        ack_block_wr = 1'b0;
        force_req = 1;
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
        chk("abort_no_pc_ld", 32'(pcld_cnt[0] - p0), 32'd0);
        chk("abort_idle_req", 32'(mif_a.mem_req), 32'd0);
        chk("abort_idle_busy", 32'(busy_a), 32'd0);

        // Second start while busy is dropped; its ir must not leak in.
        mem[12'o0020] = 12'o4567;
        ack_lat = 3;
        d0 = done_cnt[0];
        rd0 = n_rd[0];
        ir = 12'o1420;
        pclat = 12'o0000;
        pulse_start(1'b0);
        ir = 12'o1123;
        pulse_start(1'b0);
        repeat (15) @(negedge clk);
        $display("double start: dones=%0d reads=%0d ea=%04o", done_cnt[0] - d0, n_rd[0] - rd0, ea_a);
        chk("dbl_one_done", 32'(done_cnt[0] - d0), 32'd1);
        chk("dbl_one_read", 32'(n_rd[0] - rd0), 32'd1);
        chk("dbl_ea", 32'(ea_a), 32'o4567);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ea_unit.md
Name: ea_unit

Overview:
- Effective-address unit for PDP-8 memory-reference instructions (MRI, opcodes 0-5). Sits between the instruction register / program counter and the memory port.
- Consumes the latched PC (page bits) and the IR. Resolves page-zero/current-page, indirect and auto-index (0010-0017 octal) addressing.
- Produces the operand address. For JMP it also produces the PC load value and load strobe (pc_in/pc_ld), which feed the program counter's IN/LD inputs.

Parameters:
AUTOINDEX_EN, 1, 1 = indirect through absolute 0010-0017 octal does read-modify-write increment; 0 = plain indirect

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE
ir  in  12  instruction word; captured at start
pclat  in  12  latched PC of the instruction; captured at start; bits [11:7] give the current page
mem_req  out  1  memory transaction request; held until acknowledged
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  12  transaction address
mem_wdata  out  12  write data
mem_rdata  in  12  read data; valid in the cycle mem_ack is high
mem_ack  in  1  transaction complete when mem_req && mem_ack at a clock edge
busy  out  1  high from the cycle after an accepted start until done is asserted
done  out  1  one-cycle pulse; ea valid
ea  out  12  effective address; held from done until the next accepted start
pc_ld  out  1  one-cycle pulse coincident with done, only for JMP (opcode 5)
pc_in  out  12  equals ea when pc_ld is high; otherwise holds its last value

Behaviour:
- Reset: state=IDLE. mem_req, mem_we, mem_addr, mem_wdata, busy, done, ea, pc_ld, pc_in all 0.
- Field decode: op=ir[11:9], I=ir[8], Z=ir[7], off=ir[6:0].
- Direct address:
  - Z=0: {5'b0, off}.
  - Z=1: {pclat[11:7], off}.
- Auto-index condition: AUTOINDEX_EN && I && direct address in 0o0010..0o0017 (absolute). Implication: Z=1 on page 0 also qualifies.
- States: IDLE, RD, WB, DONE.
- IDLE:
  - start: capture ir and pclat, compute the direct address, set busy.
  - I=0: go to DONE with ea=direct address.
  - I=1: go to RD with mem_req=1, mem_we=0, mem_addr=direct address.
  - op 6/7: go to DONE; ea unchanged; no memory access; no pc_ld.
- RD: wait for ack with request stable.
  - On ack with auto-index: ptr=mem_rdata+1 (12-bit wrap, 7777 becomes 0000). Go to WB with mem_we=1, same mem_addr, mem_wdata=ptr.
  - On ack otherwise: ptr=mem_rdata; drop mem_req; go to DONE.
- WB: wait for ack. Then drop mem_req/mem_we and go to DONE with ptr.
- DONE: assert done for one cycle. Load ea (direct address or ptr). pc_ld=1 and pc_in=ea if op=5. Clear busy. Return to IDLE.
- Latency (start edge to done high):
  - Direct: 2 cycles.
  - Indirect: 2 + read wait cycles.
  - Auto-index: adds one write plus its wait cycles.
  - Minimum ack latency is 1 cycle after mem_req rises.
- mem_req deasserts on the cycle after the ack edge. There are never back-to-back transactions without one cycle of mem_req=0, except RD to WB, where mem_req stays high and mem_we rises.
- start while not in IDLE is ignored; no queueing.
- ir/pclat changes after start have no effect.
- reset in any state, including mid-transaction with ack pending:
  - Next edge returns to IDLE with all outputs at reset values.
  - A late mem_ack is ignored.
  - No done or pc_ld is produced.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Direct page zero: pclat=0o1234, ir=0o1123, start → no mem_req, done 2 cycles after start, ea=0o0123, pc_ld=0.
- Direct current page: pclat=0o2345, ir=0o1323 → ea=0o2323, no memory access.
- Plain indirect, slow memory: ir=0o1420, M[0o0020]=0o4567, ack 3 cycles after req → one read at 0o0020 with mem_addr stable until ack, no write, ea=0o4567, busy high throughout.
- Auto-index wrap: ir=0o3410, M[0o0010]=0o7777 → read 0o0010, then write 0o0000 to 0o0010, ea=0o0000. Repeat with AUTOINDEX_EN=0 → no write, ea=0o7777.
- JMP I current page, boundary: pclat=0o0205, ir=0o5610, M[0o0210]=0o3000 → 0o0210 is not auto-index so no write; done and pc_ld pulse together for exactly 1 cycle, pc_in=ea=0o3000. Same test with pclat=0o0005 → address 0o0010 is auto-indexed.
- Reset/abort: assert reset in WB with ack withheld → next cycle mem_req=0, busy=0, ea=0; a later ack produces nothing. A second start pulsed during busy of a normal op is ignored: exactly one done.
